// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns a signed RPM command into an A/B Gray-code
// pulse train whose edge period is K_PERIOD / |rpm| clock cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; phase generator runs on active_period
// DIV   | restoring divide K_PERIOD / mag, one quotient bit per cycle
// LOAD  | commit clamped period and direction, then back to IDLE
module quad_encoder_gen #(
   parameter int DATA_WIDTH   = 16,
   parameter int PERIOD_WIDTH = 19,
   parameter int K_PERIOD     = 367647,
   parameter int MIN_PERIOD   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rpm_valid_i,
   input  logic signed [DATA_WIDTH-1:0] rpm_data_i,
   output logic                         ready_o,
   output logic                         enc_a,
   output logic                         enc_b,
   output logic                         edge_o,
   output logic                         dir_o
);

   localparam int CNT_WIDTH = $clog2(PERIOD_WIDTH);
   localparam logic [PERIOD_WIDTH-1:0] K_VEC    = PERIOD_WIDTH'(K_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] MIN_VEC  = PERIOD_WIDTH'(MIN_PERIOD);
   localparam logic [CNT_WIDTH-1:0]    DIV_LAST = CNT_WIDTH'(PERIOD_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_LOAD
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic                      accept;
   logic [DATA_WIDTH-1:0]     mag_in;
   logic [DATA_WIDTH-1:0]     mag_q;
   logic                      sign_q;
   logic [DATA_WIDTH-1:0]     rem_q;
   logic [PERIOD_WIDTH-1:0]   quo_q;
   logic [CNT_WIDTH-1:0]      div_cnt;
   logic [DATA_WIDTH:0]       rem_shift;
   logic [DATA_WIDTH:0]       rem_sub;
   logic                      rem_ge;
   logic [DATA_WIDTH-1:0]     rem_next;
   logic [PERIOD_WIDTH-1:0]   quo_next;
   logic [PERIOD_WIDTH-1:0]   active_period;
   logic [PERIOD_WIDTH-1:0]   phase_cnt;

   assign accept = rpm_valid_i && ready_o;

   // Two's-complement negate in DATA_WIDTH bits: -32768 maps to unsigned 32768.
   assign mag_in = rpm_data_i[DATA_WIDTH-1] ? DATA_WIDTH'(~rpm_data_i + 1'b1)
                                            : DATA_WIDTH'(rpm_data_i);

   assign rem_shift = {rem_q, quo_q[PERIOD_WIDTH-1]};
   assign rem_sub   = rem_shift - {1'b0, mag_q};
   assign rem_ge    = (rem_shift >= {1'b0, mag_q});
   assign rem_next  = rem_ge ? rem_sub[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
   assign quo_next  = {quo_q[PERIOD_WIDTH-2:0], rem_ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      case (state)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (accept) begin
               state_nxt = (mag_in == '0) ? ST_LOAD : ST_DIV;
            end
         end
         ST_DIV: begin
            if (div_cnt == '0) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_q         <= '0;
         sign_q        <= 1'b0;
         rem_q         <= '0;
         quo_q         <= '0;
         div_cnt       <= '0;
         active_period <= '0;
         dir_o         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  mag_q   <= mag_in;
                  sign_q  <= rpm_data_i[DATA_WIDTH-1];
                  rem_q   <= '0;
                  quo_q   <= K_VEC;
                  div_cnt <= DIV_LAST;
               end
            end
            ST_DIV: begin
               rem_q   <= rem_next;
               quo_q   <= quo_next;
               div_cnt <= div_cnt - 1'b1;
            end
            ST_LOAD: begin
               if (mag_q == '0) begin
                  active_period <= '0;
               end else if (quo_q < MIN_VEC) begin
                  active_period <= MIN_VEC;
               end else begin
                  active_period <= quo_q;
               end
               dir_o <= sign_q;
            end
            default: begin
            end
         endcase
      end
   end

   // The >= compare lets a shortened period fire immediately instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_cnt <= '0;
         edge_o    <= 1'b0;
         enc_a     <= 1'b0;
         enc_b     <= 1'b0;
      end else if (active_period == '0) begin
         phase_cnt <= '0;
         edge_o    <= 1'b0;
      end else if (phase_cnt >= active_period - PERIOD_WIDTH'(1)) begin
         phase_cnt <= '0;
         edge_o    <= 1'b1;
         if (dir_o) begin
            enc_a <= enc_b;
            enc_b <= ~enc_a;
         end else begin
            enc_a <= ~enc_b;
            enc_b <= enc_a;
         end
      end else begin
         phase_cnt <= phase_cnt + PERIOD_WIDTH'(1);
         edge_o    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: randomized and directed RPM commands compared
// cycle by cycle against a timeline model of command latency and edge times.
module tb_quad_encoder_gen;

   localparam int K_PERIOD = 367647;

   logic               clk = 1'b0;
   logic               rst;
   logic               rpm_valid_i;
   logic signed [15:0] rpm_data_i;
   logic               ready_o;
   logic               enc_a;
   logic               enc_b;
   logic               edge_o;
   logic               dir_o;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: edge times follow last edge + period; position indexes the Gray table.
   longint     cyc = 0;
   longint     m_ref = 0;
   int         m_p = 0;
   int         m_pos = 0;
   bit         m_dir = 0;
   bit         m_edge = 0;
   bit         m_pend = 0;
   longint     m_commit = 0;
   int         m_newp = 0;
   bit         m_newdir = 0;
   logic [1:0] gray_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   quad_encoder_gen dut (
      .clk         (clk),
      .rst         (rst),
      .rpm_valid_i (rpm_valid_i),
      .rpm_data_i  (rpm_data_i),
      .ready_o     (ready_o),
      .enc_a       (enc_a),
      .enc_b       (enc_b),
      .edge_o      (edge_o),
      .dir_o       (dir_o)
   );

   always #50 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step();
      int mag;
      int q;
      cyc++;
      if (rst) begin
         m_ref = 0; m_p = 0; m_pos = 0; m_dir = 0; m_edge = 0; m_pend = 0;
         return;
      end
      m_edge = 0;
      if (m_p != 0 && cyc >= m_ref + m_p) begin
         m_edge = 1;
         m_ref  = cyc;
         m_pos  = m_dir ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
      end
      if (m_pend && cyc == m_commit) begin
         if (m_p == 0) m_ref = cyc;
         m_p    = m_newp;
         m_dir  = m_newdir;
         m_pend = 0;
      end else if (!m_pend && rpm_valid_i) begin
         mag      = (rpm_data_i < 0) ? -int'(rpm_data_i) : int'(rpm_data_i);
         q        = (mag == 0) ? 0 : K_PERIOD / mag;
         m_newp   = (mag == 0) ? 0 : ((q < 2) ? 2 : q);
         m_newdir = (rpm_data_i < 0);
         m_pend   = 1;
         m_commit = cyc + ((mag == 0) ? 1 : 20);
      end
   endtask

   task automatic tick();
      logic [1:0] ab;
      @(posedge clk);
      model_step();
      @(negedge clk);
      ab = gray_tab[m_pos];
      check_val("enc_a", 32'(enc_a), 32'(ab[1]));
      check_val("enc_b", 32'(enc_b), 32'(ab[0]));
      check_val("edge_o", 32'(edge_o), 32'(m_edge));
      check_val("dir_o", 32'(dir_o), 32'(m_dir));
      check_val("ready_o", 32'(ready_o), 32'(!m_pend));
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         rpm_valid_i = 1'b0;
         rpm_data_i  = 16'($urandom);
         tick();
      end
   endtask

   task automatic send(input int val);
      rpm_valid_i = 1'b1;
      rpm_data_i  = 16'(val);
      tick();
      rpm_valid_i = 1'b0;
   endtask

   initial begin
      int guard;
      int val;
      int len;
      rst         = 1'b1;
      rpm_valid_i = 1'b0;
      rpm_data_i  = '0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         rpm_valid_i = 1'($urandom);
         rpm_data_i  = 16'($urandom);
         tick();
      end
      rst = 1'b0;
      run(1000);

      send(1000);
      run(367 * 5 + 30);
      send(-1000);
      run(2000);
      send(0);
      run(500);

      send(-32768);
      run(25);
      check_val("period_neg_max", 32'(dut.active_period), 32'd11);
      run(200);

      send(100);
      run(21);
      guard = 0;
      while ((cyc - m_ref) < 2990 && guard < 10000) begin
         run(1);
         guard++;
      end
      check_val("wait_bound", 32'(guard < 10000), 32'd1);
      send(5000);
      run(20);
      tick();
      check_val("edge_after_load", 32'(edge_o), 32'd1);
      run(400);

      send(2000);
      run(3);
      send(-700);
      run(40);
      check_val("ignored_strobe_dir", 32'(dir_o), 32'd0);
      check_val("ignored_strobe_period", 32'(dut.active_period), 32'd183);
      run(500);

      send(500);
      run(1000);
      send(-500);
      run(1500);

      send(1);
      run(21);
      check_val("period_1rpm", 32'(dut.active_period), 32'd367647);
      run(300);

      send(3000);
      run(5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(300);
      check_val("period_after_rst", 32'(dut.active_period), 32'd0);

      for (int it = 0; it < 15; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            val = 0;
         end else begin
            val = int'($urandom_range(400, 32768));
            if ($urandom_range(0, 1) == 1) val = -val;
            else if (val == 32768) val = 32767;
         end
         send(val);
         len = int'($urandom_range(30, 1500));
         for (int c = 0; c < len; c++) begin
            rpm_valid_i = ($urandom_range(0, 15) == 0);
            rpm_data_i  = 16'($urandom_range(0, 1) ? $urandom_range(400, 20000)
                                                   : -$urandom_range(400, 20000));
            tick();
         end
         rpm_valid_i = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
